// File: rtl/sprite_palette_pkg.sv
// sprite_palette_pkg
//   Shared types and constants for the sprite palette engine:
//   - fade_cmd_e   : encodings of the fade_cmd input
//   - fade_state_e : brightness-fade FSM states
//   - DEFAULT_PAL  : 16-entry reset palette, 4 bits per channel {r,g,b}
package sprite_palette_pkg;

  typedef enum logic [1:0] {
    CMD_NONE     = 2'b00,
    CMD_FADE_OUT = 2'b01,
    CMD_FADE_IN  = 2'b10,
    CMD_RSVD     = 2'b11
  } fade_cmd_e;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    FADE_OUT = 2'b01,
    FADE_IN  = 2'b10
  } fade_state_e;

  localparam int DEF_ENTRIES = 16;

  localparam logic [11:0] DEFAULT_PAL [DEF_ENTRIES] = '{
    12'h000, 12'h125, 12'h725, 12'h085, 12'hA53, 12'h555, 12'hCCC, 12'hFFE,
    12'hF04, 12'hFA0, 12'hFE2, 12'h0E3, 12'h2AF, 12'h879, 12'hF7A, 12'hFCA
  };

  // Entries beyond the table come up black.
  function automatic logic [11:0] default_rgb12(input int i);
    return (i < DEF_ENTRIES) ? DEFAULT_PAL[i[3:0]] : 12'h000;
  endfunction

endpackage

// File: rtl/sprite_palette_engine_scale.sv
// palette_channel_scale
//   Combinational brightness scaler for one colour channel.
//   y = (c*level + MAXL) >> CH_W, evaluated at 2*CH_W+1 bits so that
//   level=MAXL returns c unchanged and level=0 returns 0.
//   Ports: c (channel in), level (brightness), y (scaled channel).
module palette_channel_scale #(
  parameter int CH_W = 4
) (
  input  logic [CH_W-1:0] c,
  input  logic [CH_W-1:0] level,
  output logic [CH_W-1:0] y
);
  localparam int PW = 2*CH_W+1;
  localparam logic [PW-1:0] MAXL_W = PW'((1 << CH_W) - 1);

  logic [PW-1:0] prod;

  assign prod = PW'(c) * PW'(level) + MAXL_W;
  assign y    = CH_W'(prod >> CH_W);
endmodule

// File: rtl/sprite_palette_engine.sv
// sprite_palette_engine
//   Palette lookup with transparent-key detection and frame-paced
//   brightness fade.
//   Ports:
//     Clk, Reset_n                 clock, synchronous active-low reset
//     wr_en/wr_index/wr_rgb        palette write port ({r,g,b})
//     rd_valid/index               lookup request, result 2 cycles later
//     frame_start/fade_cmd         fade pacing and control
//     red/green/blue/out_valid/transparent   lookup result
//     fade_busy/level              fade status and current brightness
module sprite_palette_engine
  import sprite_palette_pkg::*;
#(
  parameter int IDX_W       = 4,
  parameter int CH_W        = 4,
  parameter int TRANSP_EN   = 1,
  parameter int TRANSP_IDX  = 0,
  parameter int FADE_FRAMES = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [3*CH_W-1:0] wr_rgb,
  input  logic              rd_valid,
  input  logic [IDX_W-1:0]  index,
  input  logic              frame_start,
  input  logic [1:0]        fade_cmd,
  output logic [CH_W-1:0]   red,
  output logic [CH_W-1:0]   green,
  output logic [CH_W-1:0]   blue,
  output logic              out_valid,
  output logic              transparent,
  output logic              fade_busy,
  output logic [CH_W-1:0]   level
);
  localparam int DEPTH = 2**IDX_W;
  localparam int MAXL  = 2**CH_W - 1;
  localparam int REP   = (CH_W + 3) / 4;
  localparam int CNT_W = (FADE_FRAMES < 2) ? 1 : $clog2(FADE_FRAMES);
  localparam logic [CH_W-1:0]  LVL_MAX  = CH_W'(MAXL);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FADE_FRAMES - 1);
  localparam logic [IDX_W-1:0] KEY      = IDX_W'(TRANSP_IDX);

  // The default table is 4 bits/channel; wider channels replicate the
  // nibble (4'hC -> 8'hCC) so full scale stays full scale.
  function automatic logic [CH_W-1:0] widen(input logic [3:0] n);
    logic [4*REP-1:0] rep;
    rep = {REP{n}};
    return rep[4*REP-1 -: CH_W];
  endfunction

  function automatic logic [3*CH_W-1:0] default_entry(input int i);
    logic [11:0] e;
    e = default_rgb12(i);
    return {widen(e[11:8]), widen(e[7:4]), widen(e[3:0])};
  endfunction

  // ---------------- palette storage ----------------
  logic [3*CH_W-1:0] pal [DEPTH];

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) pal[i] <= default_entry(i);
    end else if (wr_en) begin
      pal[wr_index] <= wr_rgb;
    end
  end

  // ---------------- lookup pipeline ----------------
  // Stage 1 samples the array before this edge's write lands, so a
  // same-cycle write/read of one index returns the old entry.
  logic [2:1]              vld_pipe;
  logic [3*CH_W-1:0]       s1_rgb;
  logic [IDX_W-1:0]        s1_idx;
  logic [2:0][CH_W-1:0]    chan_in, chan_out;
  logic                    tkey;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      vld_pipe <= '0;
      s1_rgb   <= '0;
      s1_idx   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1], rd_valid};
      s1_rgb   <= pal[index];
      s1_idx   <= index;
    end
  end

  assign chan_in = s1_rgb;

  for (genvar g = 0; g < 3; g++) begin : g_scale
    palette_channel_scale #(.CH_W(CH_W)) u_scale (
      .c     (chan_in[g]),
      .level (level),
      .y     (chan_out[g])
    );
  end

  assign tkey = (TRANSP_EN != 0) && (s1_idx == KEY);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      transparent        <= 1'b0;
      {red, green, blue} <= '0;
    end else if (vld_pipe[1]) begin
      transparent        <= tkey;
      {red, green, blue} <= tkey ? '0 : chan_out;
    end else begin
      transparent        <= 1'b0;
      {red, green, blue} <= '0;
    end
  end

  assign out_valid = vld_pipe[2];

  // ---------------- fade FSM ----------------
  fade_state_e      state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CH_W-1:0]  level_nx;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      level <= LVL_MAX;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      level <= level_nx;
    end
  end

  // A frame_start arriving with the command in IDLE is not counted:
  // IDLE never advances the counter and entry clears it.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    level_nx = level;
    case (state)
      IDLE: begin
        if (fade_cmd == CMD_FADE_OUT && level != '0) begin
          state_nx = FADE_OUT;
          cnt_nx   = '0;
        end else if (fade_cmd == CMD_FADE_IN && level != LVL_MAX) begin
          state_nx = FADE_IN;
          cnt_nx   = '0;
        end
      end
      FADE_OUT: begin
        if (frame_start) begin
          if (cnt == CNT_LAST) begin
            cnt_nx   = '0;
            level_nx = level - 1'b1;
            if (level == CH_W'(1)) state_nx = IDLE;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      FADE_IN: begin
        if (frame_start) begin
          if (cnt == CNT_LAST) begin
            cnt_nx   = '0;
            level_nx = level + 1'b1;
            if (level == LVL_MAX - 1'b1) state_nx = IDLE;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign fade_busy = (state != IDLE);

endmodule

// File: tb/tb_sprite_palette_engine.sv
module tb_sprite_palette_engine;
  logic        Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Reset_n = 1'b0;
  logic        wr_en = 1'b0, rd_valid = 1'b0, frame_start = 1'b0;
  logic [3:0]  wr_index = '0, index = '0;
  logic [11:0] wr_rgb = '0;
  logic [1:0]  fade_cmd = '0;
  logic [3:0]  red, green, blue, level;
  logic        out_valid, transparent, fade_busy;

  logic        wr_en_w = 1'b0, rd_valid_w = 1'b0;
  logic [5:0]  wr_index_w = '0, index_w = '0;
  logic [23:0] wr_rgb_w = '0;
  logic [1:0]  fade_cmd_w = '0;
  logic [7:0]  red_w, green_w, blue_w, level_w;
  logic        out_valid_w, transparent_w, fade_busy_w;

  int total = 0;
  int passed = 0;

  logic [11:0] exp_pal [16] = '{
    12'h000, 12'h125, 12'h725, 12'h085, 12'hA53, 12'h555, 12'hCCC, 12'hFFE,
    12'hF04, 12'hFA0, 12'hFE2, 12'h0E3, 12'h2AF, 12'h879, 12'hF7A, 12'hFCA
  };

  sprite_palette_engine dut (
    .Clk(Clk), .Reset_n(Reset_n), .wr_en(wr_en), .wr_index(wr_index),
    .wr_rgb(wr_rgb), .rd_valid(rd_valid), .index(index),
    .frame_start(frame_start), .fade_cmd(fade_cmd), .red(red), .green(green),
    .blue(blue), .out_valid(out_valid), .transparent(transparent),
    .fade_busy(fade_busy), .level(level)
  );

  sprite_palette_engine #(.IDX_W(6), .CH_W(8)) dut_w (
    .Clk(Clk), .Reset_n(Reset_n), .wr_en(wr_en_w), .wr_index(wr_index_w),
    .wr_rgb(wr_rgb_w), .rd_valid(rd_valid_w), .index(index_w),
    .frame_start(frame_start), .fade_cmd(fade_cmd_w), .red(red_w),
    .green(green_w), .blue(blue_w), .out_valid(out_valid_w),
    .transparent(transparent_w), .fade_busy(fade_busy_w), .level(level_w)
  );

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // Single read; returns with the result on the outputs.
  task automatic read_pix(input logic [3:0] idx);
    rd_valid = 1'b1; index = idx;
    tick;
    rd_valid = 1'b0;
    tick;
  endtask

  task automatic read_pix_w(input logic [5:0] idx);
    rd_valid_w = 1'b1; index_w = idx;
    tick;
    rd_valid_w = 1'b0;
    tick;
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      frame_start = 1'b1;
      tick;
      frame_start = 1'b0;
      tick;
    end
  endtask

  task automatic test_reset;
    Reset_n = 1'b0;
    wr_en = 1'b1; wr_index = 4'd5; wr_rgb = 12'hFFF; rd_valid = 1'b1; index = 4'd3;
    wr_en_w = 1'b1; wr_index_w = 6'd2; wr_rgb_w = 24'hFFFFFF; rd_valid_w = 1'b1;
    tick; tick; tick;
    total++;
    if ({out_valid, transparent, red, green, blue, fade_busy} !== 15'h0)
      $display("FAIL reset_outs: got %h expected 0",
               {out_valid, transparent, red, green, blue, fade_busy});
    else passed++;
    total++;
    if (level !== 4'hF) $display("FAIL reset_level: got %h expected f", level);
    else passed++;
    total++;
    if (level_w !== 8'hFF || out_valid_w !== 1'b0)
      $display("FAIL reset_wide: got level %h valid %b expected ff 0", level_w, out_valid_w);
    else passed++;
    wr_en = 1'b0; rd_valid = 1'b0; wr_en_w = 1'b0; rd_valid_w = 1'b0;
    Reset_n = 1'b1;
    tick;
  endtask

  task automatic test_default_read;
    logic [13:0] exp;
    logic [13:0] got;
    for (int c = 0; c < 18; c++) begin
      if (c < 16) begin rd_valid = 1'b1; index = c[3:0]; end
      else rd_valid = 1'b0;
      tick;
      if (c >= 1 && c <= 16) exp = {1'b1, (c == 1), exp_pal[c-1]};
      else exp = 14'h0;
      got = {out_valid, transparent, red, green, blue};
      total++;
      if (got !== exp) $display("FAIL default_read[%0d]: got %h expected %h", c, got, exp);
      else passed++;
    end
  endtask

  task automatic test_collision;
    wr_en = 1'b1; wr_index = 4'd5; wr_rgb = 12'h3A7; rd_valid = 1'b1; index = 4'd5;
    tick;
    wr_en = 1'b0;
    tick;
    total++;
    if ({out_valid, red, green, blue} !== 13'h1555)
      $display("FAIL collision_old: got %h expected 1555", {out_valid, red, green, blue});
    else passed++;
    rd_valid = 1'b0;
    tick;
    total++;
    if ({out_valid, red, green, blue} !== 13'h13A7)
      $display("FAIL collision_new: got %h expected 13a7", {out_valid, red, green, blue});
    else passed++;
    tick;
  endtask

  task automatic test_fade_out;
    fade_cmd = 2'b01;
    tick;
    fade_cmd = 2'b00;
    total++;
    if (fade_busy !== 1'b1 || level !== 4'hF)
      $display("FAIL fade_start: got busy %b level %h expected 1 f", fade_busy, level);
    else passed++;
    frames(3);
    total++;
    if (level !== 4'hF) $display("FAIL fade_3frames: got %h expected f", level);
    else passed++;
    frames(1);
    total++;
    if (level !== 4'hE) $display("FAIL fade_4frames: got %h expected e", level);
    else passed++;
    wr_en = 1'b1; wr_index = 4'd7; wr_rgb = 12'hC8F;
    tick;
    wr_en = 1'b0;
    frames(24);
    total++;
    if (level !== 4'h8) $display("FAIL fade_28frames: got %h expected 8", level);
    else passed++;
    read_pix(4'd7);
    total++;
    if ({out_valid, transparent, red, green, blue} !== 14'h2648)
      $display("FAIL scale_lvl8: got %h expected 2648", {out_valid, transparent, red, green, blue});
    else passed++;
    read_pix(4'd0);
    total++;
    if ({out_valid, transparent, red, green, blue} !== 14'h3000)
      $display("FAIL transp_lvl8: got %h expected 3000", {out_valid, transparent, red, green, blue});
    else passed++;
    fade_cmd = 2'b10;
    tick;
    fade_cmd = 2'b00;
    frames(4);
    total++;
    if (level !== 4'h7 || fade_busy !== 1'b1)
      $display("FAIL fadein_ignored: got level %h busy %b expected 7 1", level, fade_busy);
    else passed++;
    frames(28);
    total++;
    if (level !== 4'h0 || fade_busy !== 1'b0)
      $display("FAIL fade_to_zero: got level %h busy %b expected 0 0", level, fade_busy);
    else passed++;
    read_pix(4'd5);
    total++;
    if ({out_valid, transparent, red, green, blue} !== 14'h2000)
      $display("FAIL black_lvl0: got %h expected 2000", {out_valid, transparent, red, green, blue});
    else passed++;
    fade_cmd = 2'b01;
    tick;
    fade_cmd = 2'b00;
    total++;
    if (fade_busy !== 1'b0 || level !== 4'h0 || out_valid !== 1'b0)
      $display("FAIL fadeout_at_zero: got busy %b level %h valid %b expected 0 0 0",
               fade_busy, level, out_valid);
    else passed++;
  endtask

  task automatic test_fade_in;
    fade_cmd = 2'b10; frame_start = 1'b1;
    tick;
    fade_cmd = 2'b00; frame_start = 1'b0;
    tick;
    total++;
    if (fade_busy !== 1'b1) $display("FAIL fadein_start: got %b expected 1", fade_busy);
    else passed++;
    frames(3);
    total++;
    if (level !== 4'h0) $display("FAIL fadein_pulse_not_counted: got %h expected 0", level);
    else passed++;
    frames(1);
    total++;
    if (level !== 4'h1) $display("FAIL fadein_step: got %h expected 1", level);
    else passed++;
  endtask

  task automatic test_reset_mid_fade;
    frames(2);
    rd_valid = 1'b1; index = 4'd5;
    tick;
    rd_valid = 1'b0; Reset_n = 1'b0;
    tick;
    total++;
    if (level !== 4'hF || fade_busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL reset_mid: got level %h busy %b valid %b expected f 0 0",
               level, fade_busy, out_valid);
    else passed++;
    Reset_n = 1'b1;
    tick;
    total++;
    if (out_valid !== 1'b0) $display("FAIL reset_abort_pix: got %b expected 0", out_valid);
    else passed++;
    read_pix(4'd7);
    total++;
    if ({out_valid, red, green, blue} !== 13'h1FFE)
      $display("FAIL reset_reload: got %h expected 1ffe", {out_valid, red, green, blue});
    else passed++;
    frames(4);
    total++;
    if (level !== 4'hF || fade_busy !== 1'b0)
      $display("FAIL idle_after_reset: got level %h busy %b expected f 0", level, fade_busy);
    else passed++;
  endtask

  task automatic test_wide;
    read_pix_w(6'd63);
    total++;
    if ({out_valid_w, red_w, green_w, blue_w} !== 25'h1000000)
      $display("FAIL wide_zero63: got %h expected 1000000", {out_valid_w, red_w, green_w, blue_w});
    else passed++;
    read_pix_w(6'd2);
    total++;
    if ({out_valid_w, red_w, green_w, blue_w} !== 25'h1772255)
      $display("FAIL wide_default2: got %h expected 1772255", {out_valid_w, red_w, green_w, blue_w});
    else passed++;
    wr_en_w = 1'b1; wr_index_w = 6'd63; wr_rgb_w = 24'hA5C31E;
    tick;
    wr_en_w = 1'b0;
    read_pix_w(6'd63);
    total++;
    if ({out_valid_w, transparent_w, red_w, green_w, blue_w} !== 26'h2A5C31E)
      $display("FAIL wide_rw63: got %h expected 2a5c31e",
               {out_valid_w, transparent_w, red_w, green_w, blue_w});
    else passed++;
  endtask

  initial begin
    test_reset;
    test_default_read;
    test_collision;
    test_fade_out;
    test_fade_in;
    test_reset_mid_fade;
    test_wide;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/sprite_palette_engine.md
SPRITE_PALETTE_ENGINE -- requirements
Module: sprite_palette_engine

Interface
REQ-001 SHALL have parameter IDX_W, default 4: palette index width; DEPTH = 2**IDX_W entries.
REQ-002 SHALL have parameter CH_W, default 4: bits per colour channel; MAXL = 2**CH_W-1.
REQ-003 SHALL have parameter TRANSP_EN, default 1: enables the transparent-index key.
REQ-004 SHALL have parameter TRANSP_IDX, default 0: index treated as transparent.
REQ-005 SHALL have parameter FADE_FRAMES, default 4: frame_start pulses per brightness step, minimum 1.
REQ-006 SHALL have port Clk, input, 1: sole clock, rising edge.
REQ-007 SHALL have port Reset_n, input, 1: synchronous active-low reset.
REQ-008 SHALL have port wr_en, input, 1: palette write strobe.
REQ-009 SHALL have port wr_index, input, IDX_W: entry to write.
REQ-010 SHALL have port wr_rgb, input, 3*CH_W: {r,g,b} write data.
REQ-011 SHALL have port rd_valid, input, 1: lookup request.
REQ-012 SHALL have port index, input, IDX_W: lookup index.
REQ-013 SHALL have port frame_start, input, 1: one-cycle pulse per video frame.
REQ-014 SHALL have port fade_cmd, input, 2: 00 none, 01 fade-out, 10 fade-in, 11 reserved/ignored.
REQ-015 SHALL have ports red, green, blue, output, CH_W each: scaled colour.
REQ-016 SHALL have port out_valid, output, 1: red/green/blue/transparent valid.
REQ-017 SHALL have port transparent, output, 1: pixel is the transparent key.
REQ-018 SHALL have port fade_busy, output, 1: fade in progress.
REQ-019 SHALL have port level, output, CH_W: current brightness.

Function
REQ-020 SHALL store DEPTH entries of 3*CH_W bits, written on wr_en at the rising edge.
REQ-021 SHALL produce lookup results exactly 2 cycles after rd_valid, fully pipelined: one result per cycle, out_valid mirroring rd_valid delayed by 2.
REQ-022 SHALL, when a write and a read target the same index in the same cycle, return the old entry; the new value is visible to reads issued the next cycle.
REQ-023 SHALL scale each channel in stage 2 as (c*level + MAXL) >> CH_W, computed at 2*CH_W+1 bits, so level=MAXL returns c exactly and level=0 returns 0.
REQ-024 SHALL use the level value sampled at stage 2 for scaling; a level change mid-stream affects only pixels reaching stage 2 afterwards.
REQ-025 SHALL assert transparent when TRANSP_EN=1 and the pipelined index equals TRANSP_IDX, forcing red/green/blue to 0 that cycle.
REQ-026 SHALL hold red/green/blue/transparent at 0 when out_valid=0.
REQ-027 SHALL implement FSM states IDLE, FADE_OUT, FADE_IN; fade_busy = (state != IDLE).
REQ-028 SHALL, in IDLE, go to FADE_OUT on fade_cmd=01 if level>0, to FADE_IN on fade_cmd=10 if level<MAXL, otherwise stay IDLE; fade_cmd is ignored outside IDLE.
REQ-029 SHALL clear the frame counter on FSM entry, count frame_start pulses, and on the FADE_FRAMES-th pulse step level by -1 (FADE_OUT) or +1 (FADE_IN) and clear the counter.
REQ-030 SHALL return to IDLE in the same cycle level reaches 0 (FADE_OUT) or MAXL (FADE_IN); level never wraps.
REQ-031 SHALL treat simultaneous fade_cmd and frame_start in IDLE as a transition only, without counting that pulse.

Reset
REQ-032 SHALL, on Reset_n=0 at a clock edge, set state IDLE, level=MAXL, frame counter 0, pipeline valids 0, and all outputs 0 except level.
REQ-033 SHALL load palette entries 0..15 from the package default table and entries 16+ with 0; a reset asserted mid-fade or mid-stream aborts it with no partial result.
REQ-034 SHALL ignore wr_en and rd_valid while Reset_n=0.

Structure
REQ-035 SHALL place fade_cmd encodings, the FSM state enum and the 16-entry default palette table in package sprite_palette_pkg.
REQ-036 SHALL put the channel scaler in sub-module palette_channel_scale, instantiated three times.

Verification
REQ-037 Reset, then read indices 0..15 back-to-back -> default entries in order, out_valid 2 cycles later, transparent only for index 0.
REQ-038 Write idx 5=12'h3A7, same cycle read idx 5, next cycle read idx 5 -> first returns the default entry, second returns 3,A,7.
REQ-039 fade_cmd=01, 4 frame_start pulses -> level 15->14; after 60 pulses -> level 0, fade_busy drops, all outputs 0.
REQ-040 Entry {C,8,F} at level 8 -> red 6, green 4, blue 8.
REQ-041 fade_cmd=10 issued during FADE_OUT -> ignored; Reset_n low mid-fade -> level 15, IDLE next cycle.
REQ-042 IDX_W=6, CH_W=8 build: write/read idx 63 -> exact data at level 255.
